// File: rtl/icache_if.sv
// Line-fill bus between the instruction cache (master) and backing memory (slave).
interface icache_if;
  logic        Mem_Req;
  logic [31:0] Mem_Addr;
  logic        Mem_Gnt;
  logic        Mem_Valid;
  logic [31:0] Mem_Data;

  modport master (
    output Mem_Req,
    output Mem_Addr,
    input  Mem_Gnt,
    input  Mem_Valid,
    input  Mem_Data
  );

  modport slave (
    input  Mem_Req,
    input  Mem_Addr,
    output Mem_Gnt,
    output Mem_Valid,
    output Mem_Data
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, 4 words per line, combinational hit lookup and
// a REQ/FILL line-fill engine that always completes a started fill.
module icache #(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Addr_fIF,
  output logic [31:0] Instr_2IF,
  output logic        Stall_2IF,
  input  logic        Invalidate,
  icache_if.master    mem,
  output logic [31:0] Hit_Count,
  output logic [31:0] Miss_Count
);

  localparam int unsigned Lines = 1 << INDEX_BITS;
  localparam int unsigned TagW  = 28 - INDEX_BITS;

  typedef enum logic [1:0] {StIdle, StReq, StFill} state_e;

  state_e                  state_q, state_d;
  logic [Lines-1:0]        valid_q, valid_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    sticky_q, sticky_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             hit_cnt_q, hit_cnt_d;
  logic [31:0]             miss_cnt_q, miss_cnt_d;
  logic [TagW-1:0]         tag_q [Lines];
  logic [31:0]             data_q [Lines][4];

  logic [INDEX_BITS-1:0]   idx, fill_idx;
  logic [TagW-1:0]         tag, fill_tag;
  logic [1:0]              word;
  logic                    hit;
  logic                    unused_addr;

  assign word        = Addr_fIF[3:2];
  assign idx         = Addr_fIF[3+INDEX_BITS:4];
  assign tag         = Addr_fIF[31:4+INDEX_BITS];
  assign fill_idx    = addr_q[3+INDEX_BITS:4];
  assign fill_tag    = addr_q[31:4+INDEX_BITS];
  assign unused_addr = ^Addr_fIF[1:0];

  assign hit       = (state_q == StIdle) && valid_q[idx] && (tag_q[idx] == tag);
  assign Instr_2IF = hit ? data_q[idx][word] : 32'h0;
  assign Stall_2IF = ~hit;

  assign mem.Mem_Req  = (state_q == StReq);
  assign mem.Mem_Addr = addr_q;
  assign Hit_Count    = hit_cnt_q;
  assign Miss_Count   = miss_cnt_q;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    addr_d     = addr_q;
    hit_cnt_d  = hit_cnt_q + {31'd0, hit};
    miss_cnt_d = miss_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!hit) begin
          state_d    = StReq;
          addr_d     = {Addr_fIF[31:4], 4'b0};
          miss_cnt_d = miss_cnt_q + 32'd1;
        end
      end
      StReq: begin
        if (mem.Mem_Gnt) begin
          state_d = StFill;
          cnt_d   = 2'd0;
        end
      end
      StFill: begin
        if (mem.Mem_Valid) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = StIdle;
            if (!sticky_q) valid_d[fill_idx] = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Invalidate wins over a same-edge fill completion; sticky covers earlier edges.
    if (Invalidate) begin
      valid_d = '0;
      if (state_q != StIdle) sticky_d = 1'b1;
    end
    if (state_d == StIdle) sticky_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      cnt_q      <= 2'd0;
      sticky_q   <= 1'b0;
      addr_q     <= 32'h0;
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
      addr_q     <= addr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Arrays are only meaningful under valid_q, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (state_q == StFill && mem.Mem_Valid) begin
      data_q[fill_idx][cnt_q] <= mem.Mem_Data;
      if (cnt_q == 2'd3) tag_q[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: cold miss, conflict, gapped fill,
// redirect, invalidate and mid-fill reset.
module tb_icache;
  logic        CLK;
  logic        RESET;
  logic [31:0] Addr_fIF;
  logic [31:0] Instr_2IF;
  logic        Stall_2IF;
  logic        Invalidate;
  logic [31:0] Hit_Count;
  logic [31:0] Miss_Count;

  icache_if bus ();

  icache #(.INDEX_BITS(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .Addr_fIF   (Addr_fIF),
    .Instr_2IF  (Instr_2IF),
    .Stall_2IF  (Stall_2IF),
    .Invalidate (Invalidate),
    .mem        (bus),
    .Hit_Count  (Hit_Count),
    .Miss_Count (Miss_Count)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are checked 2 time units after the rising edge.
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  // Entered in REQ; leaves right after the completion edge.
  task automatic do_fill(input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3,
                         input int gnt_wait, input int redir_at,
                         input logic [31:0] redir_addr, input int inv_at);
    logic [31:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < gnt_wait; i++) begin
      step();
      check_eq("req_hold", {31'd0, bus.Mem_Req}, 32'd1);
    end
    bus.Mem_Gnt = 1'b1;
    step();
    bus.Mem_Gnt = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b == redir_at) Addr_fIF = redir_addr;
      Invalidate    = (b == inv_at);
      bus.Mem_Valid = 1'b1;
      bus.Mem_Data  = d[b];
      step();
    end
    bus.Mem_Valid = 1'b0;
    bus.Mem_Data  = 32'h0;
    Invalidate    = 1'b0;
    #1;
  endtask

  initial begin
    logic [6:0] pat;
    logic [31:0] gdat [4];
    int k;
    RESET         = 1'b1;
    Addr_fIF      = 32'hBFC00000;
    Invalidate    = 1'b0;
    bus.Mem_Gnt   = 1'b0;
    bus.Mem_Valid = 1'b0;
    bus.Mem_Data  = 32'h0;
    #1 RESET = 1'b0;
    step();
    step();
    check_eq("rst_req",   {31'd0, bus.Mem_Req}, 32'd0);
    check_eq("rst_maddr", bus.Mem_Addr, 32'h0);
    check_eq("rst_hits",  Hit_Count, 32'h0);
    check_eq("rst_miss",  Miss_Count, 32'h0);
    check_eq("rst_stall", {31'd0, Stall_2IF}, 32'd1);
    check_eq("rst_instr", Instr_2IF, 32'h0);
    RESET = 1'b1;

    // Cold miss
    step();
    check_eq("cold_req",   {31'd0, bus.Mem_Req}, 32'd1);
    check_eq("cold_maddr", bus.Mem_Addr, 32'hBFC00000);
    check_eq("cold_miss",  Miss_Count, 32'd1);
    check_eq("cold_stall", {31'd0, Stall_2IF}, 32'd1);
    do_fill(32'h11, 32'h22, 32'h33, 32'h44, 2, -1, 32'h0, -1);
    check_eq("cold_w0",    Instr_2IF, 32'h11);
    check_eq("cold_nstl",  {31'd0, Stall_2IF}, 32'd0);
    check_eq("cold_reqlo", {31'd0, bus.Mem_Req}, 32'd0);
    check_eq("cold_hit0",  Hit_Count, 32'd0);
    step();
    check_eq("cold_hit1",  Hit_Count, 32'd1);
    Addr_fIF = 32'hBFC0000C; #1;
    check_eq("cold_w3",    Instr_2IF, 32'h44);
    step();
    check_eq("cold_hit2",  Hit_Count, 32'd2);
    check_eq("cold_miss1", Miss_Count, 32'd1);

    // Conflict on index 0
    Addr_fIF = 32'h00000000; #1;
    check_eq("cf_stall0", {31'd0, Stall_2IF}, 32'd1);
    step();
    do_fill(32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, -1, 32'h0, -1);
    check_eq("cf_a0", Instr_2IF, 32'hA0);
    Addr_fIF = 32'h00000100; #1;
    check_eq("cf_stall1", {31'd0, Stall_2IF}, 32'd1);
    step();
    check_eq("cf_maddr1", bus.Mem_Addr, 32'h00000100);
    do_fill(32'hB0, 32'hB1, 32'hB2, 32'hB3, 1, -1, 32'h0, -1);
    Addr_fIF = 32'h00000104; #1;
    check_eq("cf_b1", Instr_2IF, 32'hB1);
    Addr_fIF = 32'h00000000; #1;
    check_eq("cf_remiss", {31'd0, Stall_2IF}, 32'd1);
    step();
    check_eq("cf_miss", Miss_Count, 32'd4);
    check_eq("cf_maddr2", bus.Mem_Addr, 32'h00000000);
    do_fill(32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, -1, 32'h0, -1);
    Addr_fIF = 32'h00000008; #1;
    check_eq("cf_a2", Instr_2IF, 32'hA2);

    // Gapped beats: completion on the 7th FILL cycle
    Addr_fIF = 32'h00000210; #1;
    step();
    bus.Mem_Gnt = 1'b1;
    step();
    bus.Mem_Gnt = 1'b0;
    pat  = 7'b1011001;  // bit i = Mem_Valid in FILL cycle i
    gdat = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    k    = 0;
    for (int i = 0; i < 7; i++) begin
      bus.Mem_Valid = pat[i];
      bus.Mem_Data  = pat[i] ? gdat[k] : 32'hDEAD0000;
      step();
      if (pat[i]) k++;
      check_eq($sformatf("gap_stall%0d", i), {31'd0, Stall_2IF}, (i < 6) ? 32'd1 : 32'd0);
    end
    bus.Mem_Valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      Addr_fIF = 32'h00000210 + 32'(w * 4); #1;
      check_eq($sformatf("gap_w%0d", w), Instr_2IF, 32'hC0 + 32'(w));
    end

    // Redirect during fill
    Addr_fIF = 32'hBFC00000; #1;
    step();
    check_eq("rd_maddr0", bus.Mem_Addr, 32'hBFC00000);
    do_fill(32'h55, 32'h66, 32'h77, 32'h88, 1, 2, 32'h80000020, -1);
    check_eq("rd_stall", {31'd0, Stall_2IF}, 32'd1);
    check_eq("rd_reqlo", {31'd0, bus.Mem_Req}, 32'd0);
    step();
    check_eq("rd_maddr1", bus.Mem_Addr, 32'h80000020);
    check_eq("rd_req",    {31'd0, bus.Mem_Req}, 32'd1);
    do_fill(32'hD0, 32'hD1, 32'hD2, 32'hD3, 0, -1, 32'h0, -1);
    check_eq("rd_new", Instr_2IF, 32'hD0);
    Addr_fIF = 32'hBFC00008; #1;
    check_eq("rd_old", Instr_2IF, 32'h77);

    // Invalidate mid-fill, on the completing beat, and in IDLE
    Addr_fIF = 32'h00000330; #1;
    step();
    do_fill(32'hF0, 32'hF1, 32'hF2, 32'hF3, 0, -1, 32'h0, 1);
    check_eq("inv_mid", {31'd0, Stall_2IF}, 32'd1);
    step();
    check_eq("inv_maddr", bus.Mem_Addr, 32'h00000330);
    do_fill(32'hF0, 32'hF1, 32'hF2, 32'hF3, 0, -1, 32'h0, 3);
    check_eq("inv_last", {31'd0, Stall_2IF}, 32'd1);
    step();
    do_fill(32'hF0, 32'hF1, 32'hF2, 32'hF3, 0, -1, 32'h0, -1);
    Addr_fIF = 32'h00000334; #1;
    check_eq("inv_fill", Instr_2IF, 32'hF1);
    Addr_fIF = 32'h00000210; #1;
    check_eq("inv_all", {31'd0, Stall_2IF}, 32'd1);
    Addr_fIF   = 32'h00000334;
    Invalidate = 1'b1;
    step();
    Invalidate = 1'b0; #1;
    check_eq("inv_idle", {31'd0, Stall_2IF}, 32'd1);

    // Reset at beat 2 of a fill
    Addr_fIF = 32'h00000440;
    step();
    bus.Mem_Gnt = 1'b1;
    step();
    bus.Mem_Gnt = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.Mem_Valid = 1'b1;
      bus.Mem_Data  = 32'h90 + 32'(b);
      step();
    end
    bus.Mem_Valid = 1'b0;
    RESET = 1'b0; #1;
    check_eq("mr_req",   {31'd0, bus.Mem_Req}, 32'd0);
    check_eq("mr_maddr", bus.Mem_Addr, 32'h0);
    check_eq("mr_hits",  Hit_Count, 32'h0);
    check_eq("mr_miss",  Miss_Count, 32'h0);
    step();
    RESET = 1'b1; #1;
    check_eq("mr_stall", {31'd0, Stall_2IF}, 32'd1);
    step();
    check_eq("mr_remiss", Miss_Count, 32'd1);
    check_eq("mr_maddr2", bus.Mem_Addr, 32'h00000440);
    check_eq("mr_req2",   {31'd0, bus.Mem_Req}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have parameter INDEX_BITS, default 4, meaning log2 of line count (16 lines, 4 words/line, direct-mapped).
REQ-002 The block SHALL have port CLK  input  1  rising-edge clock.
REQ-003 The block SHALL have port RESET  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port Addr_fIF  input  32  fetch address from fetch stage; bits [1:0] ignored.
REQ-005 The block SHALL have port Instr_2IF  output  32  instruction word returned to fetch stage.
REQ-006 The block SHALL have port Stall_2IF  output  1  high while Instr_2IF is not valid; drives fetch STALL.
REQ-007 The block SHALL have port Invalidate  input  1  clear all valid bits.
REQ-008 The block SHALL have port Mem_Req  output  1  line-fill request to memory.
REQ-009 The block SHALL have port Mem_Addr  output  32  line-aligned fill address (bits [3:0] = 0).
REQ-010 The block SHALL have port Mem_Gnt  input  1  memory accepts request.
REQ-011 The block SHALL have port Mem_Valid  input  1  fill beat valid.
REQ-012 The block SHALL have port Mem_Data  input  32  fill beat data.
REQ-013 The block SHALL have ports Hit_Count and Miss_Count  output  32 each  access statistics.

Function
REQ-014 Address split SHALL be: word = Addr[3:2], index = Addr[3+INDEX_BITS:4], tag = Addr[31:4+INDEX_BITS].
REQ-015 Hit SHALL be: state IDLE, valid[index]=1, tag[index]=tag; hit lookup SHALL be combinational, zero-cycle latency.
REQ-016 On hit: Instr_2IF = data[index][word], Stall_2IF = 0; otherwise Instr_2IF = 32'h0, Stall_2IF = 1.
REQ-017 FSM states SHALL be IDLE, REQ, FILL; only these three.
REQ-018 IDLE: miss -> REQ at next edge, latching line address {Addr[31:4],4'b0} into Mem_Addr.
REQ-019 REQ: Mem_Req = 1, Mem_Addr stable; Mem_Gnt=1 at edge -> FILL, beat counter = 0; Mem_Req = 0 in all other states.
REQ-020 FILL: each edge with Mem_Valid=1 SHALL write Mem_Data into word[counter] of the latched line and increment counter (2-bit, wraps 3->0).
REQ-021 Beat with counter=3 SHALL write tag, set valid (unless REQ-024 applies), return to IDLE; re-lookup then hits same cycle.
REQ-022 Mem_Valid low in FILL SHALL hold state and counter; no timeout.
REQ-023 Addr_fIF changes during REQ/FILL (branch redirect) SHALL NOT abort the fill; the fetched line is installed, then IDLE re-looks-up the new address.
REQ-024 Invalidate=1 at an edge SHALL clear all valid bits; if state is REQ or FILL, a sticky flag SHALL suppress setting valid at fill completion; flag clears on return to IDLE.
REQ-025 Invalidate and fill completion on the same edge: line SHALL end invalid.
REQ-026 Hit_Count SHALL increment on each edge where hit; Miss_Count on each IDLE->REQ transition; both wrap at 2^32.
REQ-027 Data/tag arrays SHALL be written only during FILL; no write path from fetch side.

Reset
REQ-028 RESET low SHALL immediately force: state IDLE, all valid = 0, sticky flag = 0, counter = 0, Mem_Req = 0, Mem_Addr = 0, Hit_Count = 0, Miss_Count = 0.
REQ-029 Reset mid-fill SHALL abandon the fill; partially written line SHALL stay invalid; data/tag array contents need not reset.
REQ-030 After RESET release with Addr_fIF = 32'hBFC00000, first edge SHALL start a miss (Stall_2IF = 1).

Verification
REQ-031 Cold miss: Addr 0xBFC00000, Gnt after 2 cycles, beats 0x11,0x22,0x33,0x44 -> Mem_Addr 0xBFC00000, Miss_Count 1, then Instr_2IF 0x11, Stall 0; Addr 0xBFC0000C -> 0x44 hit, Hit_Count increments.
REQ-032 Conflict: fill 0x00000000 then 0x00000100 (same index 0) -> second is miss, first re-misses afterwards; Miss_Count 3.
REQ-033 Gapped beats: Mem_Valid pattern 1,0,0,1,1,0,1 -> four words written in order, completion on 7th cycle of FILL.
REQ-034 Redirect mid-fill: Addr changes 0xBFC00000 -> 0x80000020 during FILL -> 0xBFC00000 line installed, then new miss Mem_Addr 0x80000020.
REQ-035 Invalidate during FILL -> line not valid after completion; same address misses again; Invalidate in IDLE -> previously hitting address misses.
REQ-036 RESET asserted at beat 2 of FILL -> Mem_Req 0, counters 0 immediately; after release same address misses.
